// File: rtl/sd_cmd_sequencer_if.sv
// sd_cmd_sequencer_if: UART byte stream in, SD engine control/status out.
// master = sequencer side, slave = surrounding top-level logic.
interface sd_cmd_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sd_init_start;
  logic       sd_read_start;
  logic [7:0] sd_arg;
  logic       sd_init_done;
  logic       sd_init_fail;
  logic       sd_read_done;
  logic       busy;
  logic       sd_ready;
  logic       err;
  logic [2:0] err_code;

  modport master (
    input  rx_data, rx_valid,
    input  sd_init_done, sd_init_fail, sd_read_done,
    output sd_init_start, sd_read_start, sd_arg,
    output busy, sd_ready, err, err_code
  );

  modport slave (
    output rx_data, rx_valid,
    output sd_init_done, sd_init_fail, sd_read_done,
    input  sd_init_start, sd_read_start, sd_arg,
    input  busy, sd_ready, err, err_code
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: frames 00 01 <opc> <arg> from UART, drives SD init/read.
// Define CMD_TIMEOUT_EN to add the engine-done watchdog (OP_TIMEOUT).
module sd_cmd_sequencer #(
  parameter int GAP_CYCLES = 150000,
  parameter int OP_TIMEOUT = 50000000
) (
  input logic clk,
  input logic rst_n,
  sd_cmd_sequencer_if.master bus
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(OP_TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(OP_TIMEOUT);
`ifdef CMD_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_SYNC, S_CLASS, S_OPC, S_ARG, S_ISSUE, S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic          opc_q, opc_d;
  logic [7:0]    arg_q, arg_d;
  logic          ready_q, ready_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
  logic [2:0]    code_q, code_d;
  logic          in_frame, gap_exp, wd_exp;
  logic          done, hi_err;
  logic          init_start, read_start;

  assign in_frame = (state_q == S_CLASS) ||
                    (state_q == S_OPC) ||
                    (state_q == S_ARG);
  assign gap_exp = in_frame && !bus.rx_valid &&
                   (gap_q == GAP_MAX);
  assign wd_exp = WD_EN && (state_q == S_WAIT) &&
                  (wd_q == TO_MAX);
  // opc_q: 0 = INIT, 1 = READ
  assign done = opc_q ? bus.sd_read_done
                      : bus.sd_init_done;

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    arg_d      = arg_q;
    ready_d    = ready_q;
    err_d      = 1'b0;
    code_d     = code_q;
    hi_err     = 1'b0;
    init_start = 1'b0;
    read_start = 1'b0;
    gap_d      = gap_q;
    wd_d       = wd_q;

    if (!in_frame || bus.rx_valid) gap_d = '0;
    else if (gap_q != GAP_MAX) gap_d = gap_q + GW'(1);

    if (state_q != S_WAIT) wd_d = '0;
    else if (WD_EN && wd_q != TO_MAX) wd_d = wd_q + TW'(1);

    unique case (state_q)
      S_SYNC:
        if (bus.rx_valid && bus.rx_data == 8'h00)
          state_d = S_CLASS;
      S_CLASS:
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'h01) begin
            state_d = S_OPC;
          end else begin
            err_d   = 1'b1;
            code_d  = 3'd1;
            state_d = S_SYNC;
          end
        end
      S_OPC:
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'h02 ||
              bus.rx_data == 8'h03) begin
            opc_d   = bus.rx_data[0];
            state_d = S_ARG;
          end else begin
            err_d   = 1'b1;
            code_d  = 3'd2;
            state_d = S_SYNC;
          end
        end
      S_ARG:
        if (bus.rx_valid) begin
          arg_d   = bus.rx_data;
          state_d = S_ISSUE;
        end
      S_ISSUE:
        if (!opc_q) begin
          init_start = 1'b1;
          ready_d    = 1'b0;
          state_d    = S_WAIT;
        end else if (ready_q) begin
          read_start = 1'b1;
          state_d    = S_WAIT;
        end else begin
          err_d   = 1'b1;
          code_d  = 3'd3;
          state_d = S_SYNC;
        end
      S_WAIT:
        if (done) begin
          state_d = S_SYNC;
          if (!opc_q) begin
            ready_d = !bus.sd_init_fail;
            if (bus.sd_init_fail) begin
              err_d  = 1'b1;
              code_d = 3'd4;
              hi_err = 1'b1;
            end
          end
        end else if (wd_exp) begin
          err_d   = 1'b1;
          code_d  = 3'd5;
          hi_err  = 1'b1;
          ready_d = 1'b0;
          state_d = S_SYNC;
        end
      default: state_d = S_SYNC;
    endcase

    if (gap_exp) begin
      err_d   = 1'b1;
      code_d  = 3'd6;
      state_d = S_SYNC;
    end

    // a byte arriving while a command is in flight is lost
    if (bus.rx_valid && !hi_err &&
        (state_q == S_ISSUE || state_q == S_WAIT)) begin
      err_d  = 1'b1;
      code_d = 3'd7;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SYNC;
      opc_q   <= 1'b0;
      arg_q   <= '0;
      ready_q <= 1'b0;
      gap_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      arg_q   <= arg_d;
      ready_q <= ready_d;
      gap_q   <= gap_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign bus.sd_init_start = init_start;
  assign bus.sd_read_start = read_start;
  assign bus.sd_arg        = arg_q;
  assign bus.busy          = init_start | read_start |
                             (state_q == S_WAIT);
  assign bus.sd_ready      = ready_q;
  assign bus.err           = err_q;
  assign bus.err_code      = code_q;
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: directed + randomized frames against a
// transaction-level model of the command protocol.
module tb_sd_cmd_sequencer;
  localparam int GAP = 40;
  localparam int TO  = 1000;

  logic clk = 1'b0;
  logic rst_n;
  sd_cmd_sequencer_if bus();

  sd_cmd_sequencer #(
    .GAP_CYCLES(GAP),
    .OP_TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0, last_rx = 0, start_cyc = 0;
  int n_init = 0, n_read = 0, n_busy = 0, n_err = 0;
  int e_init = 0, e_read = 0, e_err = 0;
  logic [2:0] e_code = 3'd0;
  bit m_ready = 1'b0;
  logic [7:0] r_cls, r_opc, r_arg;
  int b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.rx_valid) last_rx = cyc;
    if (bus.sd_init_start) begin n_init++; start_cyc = cyc; end
    if (bus.sd_read_start) begin n_read++; start_cyc = cyc; end
    if (bus.busy) n_busy++;
    if (bus.err) n_err++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_err(input logic [2:0] c);
    e_err++;
    e_code = c;
  endtask

  task automatic status(input string tag, input bit bz);
    check({tag, " n_init"}, n_init, e_init);
    check({tag, " n_read"}, n_read, e_read);
    check({tag, " n_err"}, n_err, e_err);
    check({tag, " err_code"}, bus.err_code, e_code);
    check({tag, " sd_ready"}, bus.sd_ready, m_ready);
    check({tag, " busy"}, bus.busy, bz);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic gap_wait(input int g);
    idle(g < 0 ? $urandom_range(0, 8) : g);
  endtask

  // Full frame; engine replies d cycles after the start pulse.
  task automatic frame(input logic [7:0] cls, input logic [7:0] opc,
                       input logic [7:0] arg, input int d,
                       input bit fail, input int g);
    int a, bb;
    send_byte(8'h00);
    gap_wait(g);
    send_byte(cls);
    if (cls != 8'h01) begin
      exp_err(3'd1);
    end else begin
      gap_wait(g);
      send_byte(opc);
      if (opc != 8'h02 && opc != 8'h03) begin
        exp_err(3'd2);
      end else begin
        gap_wait(g);
        bb = n_busy;
        send_byte(arg);
        a = last_rx;
        if (opc == 8'h02 || m_ready) begin
          if (opc == 8'h02) begin
            e_init++;
            m_ready = 1'b0;
          end else begin
            e_read++;
          end
          repeat (d) tick();
          if (opc == 8'h02) begin
            bus.sd_init_done = 1'b1;
            bus.sd_init_fail = fail;
          end else begin
            bus.sd_read_done = 1'b1;
          end
          tick();
          bus.sd_init_done = 1'b0;
          bus.sd_init_fail = 1'b0;
          bus.sd_read_done = 1'b0;
          idle(2);
          check("start_latency", start_cyc, a + 1);
          check("busy_len", n_busy - bb, d + 1);
          check("sd_arg", bus.sd_arg, arg);
          if (opc == 8'h02) begin
            m_ready = !fail;
            if (fail) exp_err(3'd4);
          end
        end else begin
          exp_err(3'd3);
        end
      end
    end
    idle(2);
    status("frame", 1'b0);
  endtask

  task automatic issue_init_raw();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h00);
    e_init++;
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    idle(2);
    rst_n = 1'b1;
    m_ready = 1'b0;
    e_code = 3'd0;
  endtask

  initial begin
    bus.rx_data      = 8'h00;
    bus.rx_valid     = 1'b0;
    bus.sd_init_done = 1'b0;
    bus.sd_init_fail = 1'b0;
    bus.sd_read_done = 1'b0;
    rst_n = 1'b0;
    idle(3);
    check("rst busy", bus.busy, 1'b0);
    check("rst sd_ready", bus.sd_ready, 1'b0);
    check("rst err", bus.err, 1'b0);
    check("rst err_code", bus.err_code, 3'd0);
    check("rst init_start", bus.sd_init_start, 1'b0);
    check("rst read_start", bus.sd_read_start, 1'b0);
    check("rst sd_arg", bus.sd_arg, 8'h00);
    rst_n = 1'b1;
    idle(2);

    // init then read
    frame(8'h01, 8'h02, 8'h00, 100, 1'b0, -1);
    frame(8'h01, 8'h03, 8'h05, 17, 1'b0, -1);

    // reset drops sd_ready
    do_reset();
    idle(1);
    status("reset_idle", 1'b0);

    // read before init, then failing init
    frame(8'h01, 8'h03, 8'h00, 5, 1'b0, -1);
    frame(8'h01, 8'h02, 8'h00, 9, 1'b1, -1);

    // bad class / opcode, resync hunt
    send_byte(8'h55);
    idle(2);
    status("hunt55", 1'b0);
    frame(8'h07, 8'h00, 8'h00, 1, 1'b0, -1);
    frame(8'h01, 8'h09, 8'h00, 1, 1'b0, -1);

    // byte in the expiry cycle is still accepted
    frame(8'h01, 8'h02, 8'h3C, 4, 1'b0, GAP);

    // stall one cycle past the limit
    send_byte(8'h00);
    send_byte(8'h01);
    idle(GAP + 1);
    exp_err(3'd6);
    idle(1);
    status("gap", 1'b0);
    send_byte(8'h02);
    idle(2);
    status("gap_resync", 1'b0);

    // stray done pulses while idle
    bus.sd_init_done = 1'b1;
    bus.sd_init_fail = 1'b1;
    tick();
    bus.sd_init_done = 1'b0;
    bus.sd_init_fail = 1'b0;
    idle(2);
    status("stray_done", 1'b0);

    // byte dropped while busy, wrong-engine done ignored
    issue_init_raw();
    idle(2);
    send_byte(8'h00);
    exp_err(3'd7);
    idle(2);
    status("drop", 1'b1);
    bus.sd_read_done = 1'b1;
    tick();
    bus.sd_read_done = 1'b0;
    idle(2);
    status("wrong_done", 1'b1);
    bus.sd_init_done = 1'b1;
    tick();
    bus.sd_init_done = 1'b0;
    m_ready = 1'b1;
    idle(2);
    status("drop_done", 1'b0);
    frame(8'h01, 8'h03, 8'hA5, 3, 1'b0, -1);

    // reset mid-operation
    issue_init_raw();
    idle(3);
    check("mid busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid rst busy", bus.busy, 1'b0);
    check("mid rst sd_ready", bus.sd_ready, 1'b0);
    check("mid rst err_code", bus.err_code, 3'd0);
    idle(1);
    rst_n = 1'b1;
    m_ready = 1'b0;
    e_code = 3'd0;
    idle(1);
    frame(8'h01, 8'h02, 8'h11, 6, 1'b0, -1);

    // randomized frames
    for (int i = 0; i < 30; i++) begin
      r_cls = 8'h01;
      if ($urandom_range(0, 4) == 0) begin
        r_cls = 8'($urandom_range(0, 255));
        if (r_cls == 8'h01) r_cls = 8'h42;
      end
      r_opc = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'h03;
      if ($urandom_range(0, 5) == 0) begin
        r_opc = 8'($urandom_range(0, 255));
        if (r_opc == 8'h02 || r_opc == 8'h03) r_opc = 8'h10;
      end
      r_arg = 8'($urandom_range(0, 255));
      frame(r_cls, r_opc, r_arg, $urandom_range(1, 20),
            $urandom_range(0, 3) == 0, -1);
    end

    // engine never answers
    b0 = n_busy;
    issue_init_raw();
    idle(TO + 20);
`ifdef CMD_TIMEOUT_EN
    exp_err(3'd5);
    check("timeout busy_len", n_busy - b0, TO + 2);
    status("timeout", 1'b0);
`else
    status("no_watchdog", 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
